spu_mem: RTL and testbench
==========================

SPU_MEM -- requirements
Module: spu_mem

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 1000000, the RUN-state cycle limit before a forced abort.
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide host load ports: ld_valid in 1, ld_ready out 1, ld_sel in 1 (0=IM, 1=DM), ld_addr in 8, ld_data in 16.
REQ-005 SHALL provide host control ports: run in 1 (start request), busy out 1, done out 1, timeout out 1, result_ok out 1.
REQ-006 SHALL provide SPU-side ports: start out 1, stop in 1, im_addr in 8, im_rd in 1, im_r_data out 16.
REQ-007 SHALL provide SPU-side data ports: dm_addr in 8, dm_rd in 1, dm_wr in 1, dm_w_data in 16, dm_r_data out 16.

Function
REQ-008 SHALL hold two 256x16 arrays, IM and DM; contents are not reset.
REQ-009 SHALL implement FSM states IDLE, START, RUN, CHECK, DONE.
REQ-010 SHALL assert ld_ready only in IDLE and DONE; a load writes ld_data to IM or DM at ld_addr on the edge where ld_valid and ld_ready are both 1.
REQ-011 SHALL leave IDLE or DONE for START on a cycle with run=1; a load in that same cycle still completes; run in any other state is ignored.
REQ-012 SHALL assert start for exactly one cycle (the START state) and then enter RUN.
REQ-013 SHALL in RUN register IM[im_addr] into im_r_data when im_rd=1 and DM[dm_addr] into dm_r_data when dm_rd=1, visible one cycle later; each holds its value otherwise.
REQ-014 SHALL in RUN write dm_w_data to DM[dm_addr] when dm_wr=1.
REQ-015 SHALL return old data when dm_rd and dm_wr target the same address in one cycle (read-before-write).
REQ-016 SHALL ignore im_rd, dm_rd and dm_wr outside RUN.
REQ-017 SHALL sample stop only in RUN; stop=1 moves the FSM to CHECK (or to DONE when the check is compiled out).
REQ-018 SHALL count RUN cycles from 0; at count TIMEOUT-1 without stop, go to DONE with timeout=1 and result_ok=0.
REQ-019 SHALL in CHECK spend exactly 3 cycles reading DM[0], DM[1], DM[9], then set result_ok=1 iff DM[9] == (DM[0]+DM[1]) mod 2^16, then enter DONE.
REQ-020 SHALL drive busy=1 in START, RUN and CHECK, and done=1 only in DONE.
REQ-021 SHALL clear timeout and result_ok on entry to START.
REQ-022 SHALL give stop priority over timeout when both occur in the same cycle.

Reset
REQ-023 SHALL on rst=0 immediately force state IDLE and drive start, busy, done, timeout, result_ok, im_r_data and dm_r_data to 0, with ld_ready=1 after release.
REQ-024 SHALL abort any run when reset is asserted mid-operation; no further DM write occurs until the next RUN.

Configuration
REQ-025 SHALL compile the CHECK state and comparator when macro SPU_MEM_CHECK_EN is defined.
REQ-026 SHALL, without SPU_MEM_CHECK_EN, go RUN->DONE directly on stop and tie result_ok to 0.

Verification
REQ-027 SHALL cover this load and readback case: load IM[0]=16'h1234 and DM[5]=16'hABCD, run, SPU im_rd addr 0 and dm_rd addr 5 -> im_r_data=16'h1234 and dm_r_data=16'hABCD one cycle later.
REQ-028 SHALL cover this pass case: DM[0]=16'h0003, DM[1]=16'h0004, SPU writes DM[9]=16'h0007 then stop -> done=1 3 cycles after CHECK entry, result_ok=1 (check enabled).
REQ-029 SHALL cover this wrap case: DM[0]=16'hFFFF, DM[1]=16'h0002, DM[9]=16'h0001 -> result_ok=1; with DM[9]=16'h0002 -> result_ok=0.
REQ-030 SHALL cover this collision case: same-cycle dm_rd and dm_wr to addr 7 (old 16'h0011, new 16'h0022) -> dm_r_data=16'h0011; the next read gives 16'h0022.
REQ-031 SHALL cover this timeout case: TIMEOUT=16, stop never asserted -> done=1 and timeout=1 after 16 RUN cycles; ld_ready=1 and run restarts with timeout cleared.
REQ-032 SHALL cover this reset case: rst=0 during RUN -> all outputs 0 asynchronously; an SPU dm_wr after release is ignored while the FSM is in IDLE.

Source files
------------

// File: rtl/spu_mem.sv
// SPU instruction/data memory wrapper with host load port and run/stop/check sequencer.
// Define SPU_MEM_CHECK_EN to build the post-run DM[9] == DM[0]+DM[1] result check.
module spu_mem #(
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_sel,
    input  logic [7:0]  ld_addr,
    input  logic [15:0] ld_data,
    input  logic        run,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        result_ok,
    output logic        start,
    input  logic        stop,
    input  logic [7:0]  im_addr,
    input  logic        im_rd,
    output logic [15:0] im_r_data,
    input  logic [7:0]  dm_addr,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_w_data,
    output logic [15:0] dm_r_data
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_CHECK, S_DONE} state_t;

    state_t        r_state;
    logic [15:0]   r_im [256];
    logic [15:0]   r_dm [256];
    logic          r_start, r_busy, r_done, r_timeout;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_im_rdata, r_dm_rdata;
    logic          w_ld_fire, w_spu_wr;
`ifdef SPU_MEM_CHECK_EN
    logic [1:0]    r_chk;
    logic [15:0]   r_a, r_b;
    logic          r_result_ok;
`endif

    assign ld_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_ld_fire = ld_valid && ld_ready;
    assign w_spu_wr  = (r_state == S_RUN) && dm_wr;

    // Host loads and SPU writes are never live in the same state, so one port suffices.
    always_ff @(posedge clk) begin
        if (w_ld_fire && !ld_sel)
            r_im[ld_addr] <= ld_data;
        if (w_ld_fire && ld_sel)
            r_dm[ld_addr] <= ld_data;
        else if (w_spu_wr)
            r_dm[dm_addr] <= dm_w_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_im_rdata <= '0;
            r_dm_rdata <= '0;
`ifdef SPU_MEM_CHECK_EN
            r_chk       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result_ok <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            if (r_state == S_RUN) begin
                if (im_rd) r_im_rdata <= r_im[im_addr];
                if (dm_rd) r_dm_rdata <= r_dm[dm_addr];
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        r_state   <= S_START;
                        r_start   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
`ifdef SPU_MEM_CHECK_EN
                        r_result_ok <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end
                S_RUN: begin
                    // stop wins over a timeout landing in the same cycle
                    if (stop) begin
`ifdef SPU_MEM_CHECK_EN
                        r_state <= S_CHECK;
                        r_chk   <= '0;
`else
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else if (r_cnt == LAST) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef SPU_MEM_CHECK_EN
                S_CHECK: begin
                    r_chk <= r_chk + 1'b1;
                    case (r_chk)
                        2'd0:    r_a <= r_dm[0];
                        2'd1:    r_b <= r_dm[1];
                        default: begin
                            r_result_ok <= (r_dm[9] == 16'(r_a + r_b));
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    endcase
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start     = r_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign im_r_data = r_im_rdata;
    assign dm_r_data = r_dm_rdata;
`ifdef SPU_MEM_CHECK_EN
    assign result_ok = r_result_ok;
`else
    assign result_ok = 1'b0;
`endif

endmodule

// File: tb/tb_spu_mem.sv
// Randomized bench for spu_mem against a memory-array reference model.
module tb_spu_mem;
    localparam int TO = 16;
`ifdef SPU_MEM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        ld_valid = 1'b0, ld_sel = 1'b0, run = 1'b0, stop = 1'b0;
    logic [7:0]  ld_addr = '0, im_addr = '0, dm_addr = '0;
    logic [15:0] ld_data = '0, dm_w_data = '0;
    logic        im_rd = 1'b0, dm_rd = 1'b0, dm_wr = 1'b0;
    logic        ld_ready, busy, done, timeout, result_ok, start;
    logic [15:0] im_r_data, dm_r_data;

    spu_mem #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .run(run), .busy(busy), .done(done), .timeout(timeout), .result_ok(result_ok),
        .start(start), .stop(stop), .im_addr(im_addr), .im_rd(im_rd), .im_r_data(im_r_data),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_w_data(dm_w_data), .dm_r_data(dm_r_data)
    );

    always #5 clk = ~clk;

    logic [15:0] im_m [256];
    logic [15:0] dm_m [256];
    logic [15:0] e_im = '0, e_dm = '0;
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic sel, input logic [7:0] a, input logic [15:0] d);
        ld_valid = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 1'b0;
        if (sel) dm_m[a] = d; else im_m[a] = d;
    endtask

    // One SPU cycle while in RUN; model reads see the pre-write contents.
    task automatic spu(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                       input logic [7:0] da, input logic [15:0] wd);
        im_rd = ir; im_addr = ia; dm_rd = dr; dm_wr = dw; dm_addr = da; dm_w_data = wd;
        tick();
        im_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
        if (ir) e_im = im_m[ia];
        if (dr) e_dm = dm_m[da];
        if (dw) dm_m[da] = wd;
    endtask

    task automatic start_run;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk1("start_pulse", start, 1'b1);
        chk1("start_busy", busy, 1'b1);
        chk1("start_ld_ready", ld_ready, 1'b0);
        chk1("start_timeout_clr", timeout, 1'b0);
        chk1("start_result_clr", result_ok, 1'b0);
        tick();
        chk1("run_start_low", start, 1'b0);
        chk1("run_busy", busy, 1'b1);
    endtask

    // Stop, then hammer the SPU port (must be ignored) until done.
    task automatic finish_stop(input string tag, input logic exp_ok);
        int n;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        dm_wr = 1'b1; dm_rd = 1'b1; dm_addr = 8'd9; dm_w_data = ~dm_m[9];
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        dm_wr = 1'b0; dm_rd = 1'b0;
        chk({tag, "_latency"}, 16'(n), CHK ? 16'd3 : 16'd0);
        chk1({tag, "_done"}, done, 1'b1);
        chk1({tag, "_result_ok"}, result_ok, exp_ok && CHK);
        chk1({tag, "_timeout"}, timeout, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_ld_ready"}, ld_ready, 1'b1);
        chk({tag, "_dm_hold"}, dm_r_data, e_dm);
    endtask

    initial begin
        logic [15:0] r;
        int n;

        #2 rst = 1'b0;
        #3;
        chk1("rst_start", start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_result_ok", result_ok, 1'b0);
        chk("rst_im_r", im_r_data, 16'h0);
        chk("rst_dm_r", dm_r_data, 16'h0);
        @(negedge clk) rst = 1'b1;
        tick();
        chk1("rst_ld_ready", ld_ready, 1'b1);

        for (int i = 0; i < 256; i++) begin
            ld(1'b0, 8'(i), 16'($urandom));
            ld(1'b1, 8'(i), 16'($urandom));
        end
        ld(1'b0, 8'd0, 16'h1234);
        ld(1'b1, 8'd5, 16'hABCD);
        ld(1'b1, 8'd7, 16'h0011);
        ld(1'b1, 8'd0, 16'h0003);
        ld(1'b1, 8'd1, 16'h0004);

        // Load in the same cycle as run still lands.
        r = 16'($urandom);
        ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'd20; ld_data = r;
        dm_m[20] = r;
        start_run();
        ld_valid = 1'b0;

        spu(1'b1, 8'd0, 1'b1, 1'b0, 8'd5, 16'h0);
        chk("readback_im", im_r_data, 16'h1234);
        chk("readback_dm", dm_r_data, 16'hABCD);
        spu(1'b0, 8'd0, 1'b1, 1'b0, 8'd20, 16'h0);
        chk("load_with_run", dm_r_data, e_dm);
        spu(1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 16'h0022);
        chk("collision_old", dm_r_data, 16'h0011);
        spu(1'b0, 8'd0, 1'b1, 1'b0, 8'd7, 16'h0);
        chk("collision_new", dm_r_data, 16'h0022);

        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'd0; ld_data = 16'hDEAD;
            spu(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom_range(10, 255)), 16'($urandom));
            ld_valid = 1'b0;
            chk("rand_im", im_r_data, e_im);
            chk("rand_dm", dm_r_data, e_dm);
            chk1("rand_ld_ready", ld_ready, 1'b0);
        end

        spu(1'b0, 8'd0, 1'b0, 1'b1, 8'd9, 16'h0007);
        finish_stop("pass", 1'b1);

        // Wrap case; stop lands on the final RUN cycle and must beat the timeout.
        ld(1'b1, 8'd0, 16'hFFFF);
        ld(1'b1, 8'd1, 16'h0002);
        ld(1'b1, 8'd9, 16'h0001);
        start_run();
        for (int i = 0; i < TO - 1; i++) tick();
        finish_stop("wrap_ok", 16'(dm_m[0] + dm_m[1]) == dm_m[9]);

        ld(1'b1, 8'd9, 16'h0002);
        start_run();
        finish_stop("wrap_bad", 16'(dm_m[0] + dm_m[1]) == dm_m[9]);

        start_run();
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 16'(n), 16'(TO));
        chk1("timeout_flag", timeout, 1'b1);
        chk1("timeout_result", result_ok, 1'b0);
        chk1("timeout_busy", busy, 1'b0);
        chk1("timeout_ld_ready", ld_ready, 1'b1);
        start_run();
        finish_stop("after_timeout", 16'(dm_m[0] + dm_m[1]) == dm_m[9]);

        // Asynchronous reset mid-run.
        start_run();
        spu(1'b1, 8'd3, 1'b1, 1'b0, 8'd5, 16'h0);
        chk("pre_rst_dm", dm_r_data, e_dm);
        #2 rst = 1'b0;
        #1;
        e_im = '0; e_dm = '0;
        chk1("arst_start", start, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_done", done, 1'b0);
        chk1("arst_timeout", timeout, 1'b0);
        chk1("arst_result_ok", result_ok, 1'b0);
        chk("arst_im_r", im_r_data, e_im);
        chk("arst_dm_r", dm_r_data, e_dm);
        @(negedge clk) rst = 1'b1;
        dm_wr = 1'b1; dm_addr = 8'd30; dm_w_data = ~dm_m[30];
        tick();
        tick();
        dm_wr = 1'b0;
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_ld_ready", ld_ready, 1'b1);
        start_run();
        spu(1'b0, 8'd0, 1'b1, 1'b0, 8'd30, 16'h0);
        chk("idle_wr_ignored", dm_r_data, e_dm);
        finish_stop("final", 16'(dm_m[0] + dm_m[1]) == dm_m[9]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
